mdl_ntt_sched: RTL and testbench

MDL_NTT_SCHED -- requirements
Module: MDL_ntt_sched

---
 rtl/mdl_ntt_sched_if.sv | 33 +++
 rtl/mdl_ntt_sched.sv | 172 +++++++++++++++++
 tb/tb_mdl_ntt_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdl_ntt_sched_if.sv
// rtl/mdl_ntt_sched_if.sv - control and coefficient-RAM address bus of the NTT scheduler
interface mdl_ntt_sched_if #(
  parameter int LOGN = 8
) ();
  logic            iSTART;
  logic [1:0]      iMODE;
  logic            oBUSY;
  logic            oDONE;
  logic            oERR;
  logic            oRD_EN;
  logic [LOGN-1:0] oRD_ADDR_A;
  logic [LOGN-1:0] oRD_ADDR_B;
  logic [LOGN-1:0] oTW_ADDR;
  logic            oBUT_SEL;
  logic            oBUT_START;
  logic            oWR_EN;
  logic [LOGN-1:0] oWR_ADDR_A;
  logic [LOGN-1:0] oWR_ADDR_B;

  // Scheduler side
  modport master (
    input  iSTART, iMODE,
    output oBUSY, oDONE, oERR, oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR,
           oBUT_SEL, oBUT_START, oWR_EN, oWR_ADDR_A, oWR_ADDR_B
  );

  // Requester / datapath side
  modport slave (
    output iSTART, iMODE,
    input  oBUSY, oDONE, oERR, oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR,
           oBUT_SEL, oBUT_START, oWR_EN, oWR_ADDR_A, oWR_ADDR_B
  );
endinterface

// File: rtl/mdl_ntt_sched.sv
// rtl/mdl_ntt_sched.sv - NTT (CT/GS) and point-wise multiply address scheduler
module mdl_ntt_sched #(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int LAT  = 5
) (
  input logic             iSYS_CLK,
  input logic             iSYS_RST,
  mdl_ntt_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [1:0]      MODE_CT    = 2'b00;
  localparam logic [1:0]      MODE_GS    = 2'b01;
  localparam logic [1:0]      MODE_PWM   = 2'b10;
  localparam logic [1:0]      MODE_BAD   = 2'b11;
  localparam logic [LOGN-1:0] ONE        = LOGN'(1);
  localparam logic [LOGN-1:0] LAST_PAIR  = LOGN'(N/2 - 1);
  localparam logic [LOGN-1:0] LAST_COEF  = LOGN'(N - 1);
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);
  localparam logic [3:0]      LAST_DRAIN = 4'(LAT - 1);

  state_t          state;
  state_t          nextState;
  logic [1:0]      modeLatched;
  logic [LOGN-1:0] stage;
  logic [LOGN-1:0] pairIdx;
  logic [LOGN-1:0] twIdx;
  logic [3:0]      drainCnt;
  logic            errPulse;

  logic            isPwm;
  logic            isGs;
  logic            lastInStage;
  logic            groupEnd;
  logic [LOGN-1:0] lowMask;
  logic [LOGN-1:0] addrA;
  logic [LOGN-1:0] addrB;

  logic            rdEn;
  logic [LOGN-1:0] rdAddrA;
  logic [LOGN-1:0] rdAddrB;
  logic [LOGN-1:0] twAddr;
  logic            busy;

  logic            wrEnPipe [LAT];
  logic [LOGN-1:0] wrAPipe  [LAT];
  logic [LOGN-1:0] wrBPipe  [LAT];

  assign isPwm       = (modeLatched == MODE_PWM);
  assign isGs        = (modeLatched == MODE_GS);
  assign lastInStage = isPwm ? (pairIdx == LAST_COEF) : (pairIdx == LAST_PAIR);

  // Butterfly span minus one: CT halves the span each stage, GS doubles it
  always_comb begin
    lowMask = LAST_PAIR >> stage;
    if (isGs) lowMask = (ONE << stage) - ONE;
  end

  // Insert a zero bit at the span position of the pair index to get operand A
  assign addrA    = ((pairIdx & ~lowMask) << 1) | (pairIdx & lowMask);
  assign addrB    = addrA + lowMask + ONE;
  assign groupEnd = ((pairIdx & lowMask) == lowMask);

  // State register
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (bus.iSTART && (bus.iMODE != MODE_BAD)) nextState = ISSUE;
      ISSUE: if (lastInStage) nextState = DRAIN;
      DRAIN: if (drainCnt == LAST_DRAIN)
               nextState = (isPwm || (stage == LAST_STAGE)) ? DONE : ISSUE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Mode latch, stage/pair/twiddle/drain counters and the illegal-mode pulse
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      modeLatched <= MODE_CT;
      stage       <= '0;
      pairIdx     <= '0;
      twIdx       <= '0;
      drainCnt    <= '0;
      errPulse    <= 1'b0;
    end else begin
      errPulse <= (state == IDLE) && bus.iSTART && (bus.iMODE == MODE_BAD);
      case (state)
        IDLE: begin
          if (bus.iSTART && (bus.iMODE != MODE_BAD)) begin
            modeLatched <= bus.iMODE;
            stage       <= '0;
            pairIdx     <= '0;
            drainCnt    <= '0;
            twIdx       <= (bus.iMODE == MODE_GS) ? LAST_COEF : ONE;
          end
        end
        ISSUE: begin
          pairIdx  <= lastInStage ? '0 : pairIdx + ONE;
          drainCnt <= '0;
          if (!isPwm && groupEnd) twIdx <= isGs ? twIdx - ONE : twIdx + ONE;
        end
        DRAIN: begin
          drainCnt <= drainCnt + 4'd1;
          if (drainCnt == LAST_DRAIN) stage <= stage + ONE;
        end
        default: ;
      endcase
    end
  end

  // Output decode; addresses are forced to zero outside ISSUE
  always_comb begin
    busy    = (state != IDLE);
    rdEn    = (state == ISSUE);
    rdAddrA = '0;
    rdAddrB = '0;
    twAddr  = '0;
    if (rdEn) begin
      if (isPwm) begin
        rdAddrA = pairIdx;
        twAddr  = pairIdx;
      end else begin
        rdAddrA = addrA;
        rdAddrB = addrB;
        twAddr  = twIdx;
      end
    end
  end

  // Write-back delay line matching the butterfly latency
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      for (int i = 0; i < LAT; i++) begin
        wrEnPipe[i] <= 1'b0;
        wrAPipe[i]  <= '0;
        wrBPipe[i]  <= '0;
      end
    end else begin
      wrEnPipe[0] <= rdEn;
      wrAPipe[0]  <= rdAddrA;
      wrBPipe[0]  <= rdAddrB;
      for (int i = 1; i < LAT; i++) begin
        wrEnPipe[i] <= wrEnPipe[i-1];
        wrAPipe[i]  <= wrAPipe[i-1];
        wrBPipe[i]  <= wrBPipe[i-1];
      end
    end
  end

  assign bus.oBUSY      = busy;
  assign bus.oDONE      = (state == DONE);
  assign bus.oERR       = errPulse;
  assign bus.oRD_EN     = rdEn;
  assign bus.oRD_ADDR_A = rdAddrA;
  assign bus.oRD_ADDR_B = rdAddrB;
  assign bus.oTW_ADDR   = twAddr;
  assign bus.oBUT_SEL   = busy && isGs;
  assign bus.oBUT_START = busy;
  assign bus.oWR_EN     = wrEnPipe[LAT-1];
  assign bus.oWR_ADDR_A = wrAPipe[LAT-1];
  assign bus.oWR_ADDR_B = wrBPipe[LAT-1];

endmodule

// File: tb/tb_mdl_ntt_sched.sv
// tb/tb_mdl_ntt_sched.sv - randomized reference-model bench for mdl_ntt_sched
module tb_mdl_ntt_sched;

  localparam int LAT  = 5;
  localparam int MAXC = 1200;

  logic sysClk = 1'b0;
  logic sysRst;
  logic sel256;
  int   testCnt = 0;
  int   failCnt = 0;

  int expRd [MAXC];
  int expA  [MAXC];
  int expB  [MAXC];
  int expTw [MAXC];
  int expWr [MAXC];
  int expWA [MAXC];
  int expWB [MAXC];
  int modelDone;

  logic [31:0] obsBusy, obsDone, obsErr, obsRdEn, obsRdA, obsRdB, obsTw;
  logic [31:0] obsSel, obsBStart, obsWrEn, obsWA, obsWB;

  mdl_ntt_sched_if #(.LOGN(3)) bus8 ();
  mdl_ntt_sched_if #(.LOGN(8)) bus256 ();

  mdl_ntt_sched #(.N(8), .LOGN(3), .LAT(LAT)) dut8 (
    .iSYS_CLK(sysClk), .iSYS_RST(sysRst), .bus(bus8)
  );
  mdl_ntt_sched #(.N(256), .LOGN(8), .LAT(LAT)) dut256 (
    .iSYS_CLK(sysClk), .iSYS_RST(sysRst), .bus(bus256)
  );

  always #5 sysClk = ~sysClk;

  assign obsBusy   = sel256 ? 32'(bus256.oBUSY)      : 32'(bus8.oBUSY);
  assign obsDone   = sel256 ? 32'(bus256.oDONE)      : 32'(bus8.oDONE);
  assign obsErr    = sel256 ? 32'(bus256.oERR)       : 32'(bus8.oERR);
  assign obsRdEn   = sel256 ? 32'(bus256.oRD_EN)     : 32'(bus8.oRD_EN);
  assign obsRdA    = sel256 ? 32'(bus256.oRD_ADDR_A) : 32'(bus8.oRD_ADDR_A);
  assign obsRdB    = sel256 ? 32'(bus256.oRD_ADDR_B) : 32'(bus8.oRD_ADDR_B);
  assign obsTw     = sel256 ? 32'(bus256.oTW_ADDR)   : 32'(bus8.oTW_ADDR);
  assign obsSel    = sel256 ? 32'(bus256.oBUT_SEL)   : 32'(bus8.oBUT_SEL);
  assign obsBStart = sel256 ? 32'(bus256.oBUT_START) : 32'(bus8.oBUT_START);
  assign obsWrEn   = sel256 ? 32'(bus256.oWR_EN)     : 32'(bus8.oWR_EN);
  assign obsWA     = sel256 ? 32'(bus256.oWR_ADDR_A) : 32'(bus8.oWR_ADDR_A);
  assign obsWB     = sel256 ? 32'(bus256.oWR_ADDR_B) : 32'(bus8.oWR_ADDR_B);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic driveIn(input logic s, input logic [1:0] m);
    if (sel256) begin
      bus256.iSTART = s;
      bus256.iMODE  = m;
    end else begin
      bus8.iSTART = s;
      bus8.iMODE  = m;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_busy"},  obsBusy,   0);
    checkVal({tag, "_done"},  obsDone,   0);
    checkVal({tag, "_err"},   obsErr,    0);
    checkVal({tag, "_rden"},  obsRdEn,   0);
    checkVal({tag, "_rda"},   obsRdA,    0);
    checkVal({tag, "_rdb"},   obsRdB,    0);
    checkVal({tag, "_tw"},    obsTw,     0);
    checkVal({tag, "_sel"},   obsSel,    0);
    checkVal({tag, "_bst"},   obsBStart, 0);
    checkVal({tag, "_wren"},  obsWrEn,   0);
    checkVal({tag, "_wra"},   obsWA,     0);
    checkVal({tag, "_wrb"},   obsWB,     0);
  endtask

  function automatic void putOp(input int cy, input int a, input int b, input int tw);
    expRd[cy]     = 1;
    expA[cy]      = a;
    expB[cy]      = b;
    expTw[cy]     = tw;
    expWr[cy+LAT] = 1;
    expWA[cy+LAT] = a;
    expWB[cy+LAT] = b;
  endfunction

  // Cycle-indexed expectation of reads/writes, cycle 1 being the first after the start sample
  function automatic void buildModel(input int n, input logic [1:0] m);
    int cy, k, len;
    for (int c = 0; c < MAXC; c++) begin
      expRd[c] = 0; expA[c] = 0; expB[c] = 0; expTw[c] = 0;
      expWr[c] = 0; expWA[c] = 0; expWB[c] = 0;
    end
    cy = 1;
    if (m == 2'b10) begin
      for (int i = 0; i < n; i++) begin
        putOp(cy, i, 0, i);
        cy++;
      end
      cy += LAT;
    end else begin
      k = (m == 2'b00) ? 1 : n - 1;
      for (int s = 0; (1 << s) < n; s++) begin
        len = (m == 2'b00) ? (n >> (s + 1)) : (1 << s);
        for (int g = 0; g < n / (2 * len); g++) begin
          for (int t = 0; t < len; t++) begin
            putOp(cy, g * 2 * len + t, g * 2 * len + t + len, k);
            cy++;
          end
          k = (m == 2'b00) ? k + 1 : k - 1;
        end
        cy += LAT;
      end
    end
    modelDone = cy;
  endfunction

  task automatic runOp(input bit big, input logic [1:0] m, input int expDone,
                       input bit noise, input int abortAt);
    int doneAt, firstRd, firstWr;
    logic [1:0] nm;
    sel256 = big;
    buildModel(big ? 256 : 8, m);
    repeat ($urandom_range(0, 3)) tick();
    driveIn(1'b1, m);
    tick();
    driveIn(1'b0, m);
    doneAt = -1; firstRd = -1; firstWr = -1;
    for (int c = 1; c <= modelDone + 3; c++) begin
      checkVal($sformatf("m%0d_c%0d_busy", m, c), obsBusy, (c <= modelDone) ? 1 : 0);
      checkVal($sformatf("m%0d_c%0d_bst", m, c), obsBStart, (c <= modelDone) ? 1 : 0);
      checkVal($sformatf("m%0d_c%0d_sel", m, c), obsSel, (c <= modelDone && m == 2'b01) ? 1 : 0);
      checkVal($sformatf("m%0d_c%0d_done", m, c), obsDone, (c == modelDone) ? 1 : 0);
      checkVal($sformatf("m%0d_c%0d_err", m, c), obsErr, 0);
      checkVal($sformatf("m%0d_c%0d_rden", m, c), obsRdEn, expRd[c]);
      if (expRd[c] == 1) begin
        checkVal($sformatf("m%0d_c%0d_rda", m, c), obsRdA, expA[c]);
        checkVal($sformatf("m%0d_c%0d_tw", m, c), obsTw, expTw[c]);
        if (m != 2'b10) checkVal($sformatf("m%0d_c%0d_rdb", m, c), obsRdB, expB[c]);
      end
      checkVal($sformatf("m%0d_c%0d_wren", m, c), obsWrEn, expWr[c]);
      if (expWr[c] == 1) begin
        checkVal($sformatf("m%0d_c%0d_wra", m, c), obsWA, expWA[c]);
        if (m != 2'b10) checkVal($sformatf("m%0d_c%0d_wrb", m, c), obsWB, expWB[c]);
      end
      if (obsRdEn == 1 && obsWrEn == 1) begin
        checkVal($sformatf("m%0d_c%0d_raw", m, c),
                 ((obsRdA == obsWA) ||
                  (m != 2'b10 && (obsRdA == obsWB || obsRdB == obsWA || obsRdB == obsWB))) ? 1 : 0, 0);
      end
      if (obsDone == 1 && doneAt < 0) doneAt = c;
      if (obsRdEn == 1 && firstRd < 0) firstRd = c;
      if (obsWrEn == 1 && firstWr < 0) firstWr = c;
      if (c == abortAt) begin
        driveIn(1'b0, m);
        sysRst = 1'b1;
        tick();
        checkAllZero("abort");
        sysRst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          tick();
          checkVal($sformatf("abort_%0d_wren", i), obsWrEn, 0);
          checkVal($sformatf("abort_%0d_busy", i), obsBusy, 0);
        end
        return;
      end
      if (noise && c < modelDone) begin
        nm = 2'($urandom_range(0, 3));
        driveIn(($urandom_range(0, 3) == 0) || (c == 10), (c == 10) ? 2'b10 : nm);
      end else begin
        driveIn(1'b0, m);
      end
      tick();
    end
    checkVal($sformatf("m%0d_done_cycle", m), doneAt, expDone);
    checkVal($sformatf("m%0d_wr_lag", m), firstWr - firstRd, LAT);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int errCnt;
    logic [1:0] rm;
    sysRst = 1'b1;
    sel256 = 1'b0;
    bus8.iSTART   = 1'b0; bus8.iMODE   = 2'b00;
    bus256.iSTART = 1'b0; bus256.iMODE = 2'b00;
    repeat (3) tick();
    checkAllZero("rst8");
    sel256 = 1'b1;
    #1;
    checkAllZero("rst256");
    sysRst = 1'b0;
    tick();

    runOp(1'b0, 2'b00, 28, 1'b0, -1);
    runOp(1'b0, 2'b01, 28, 1'b0, -1);
    runOp(1'b1, 2'b10, 262, 1'b0, -1);

    sel256 = 1'b0;
    tick();
    driveIn(1'b1, 2'b11);
    tick();
    driveIn(1'b0, 2'b00);
    errCnt = 0;
    for (int c = 1; c <= 4; c++) begin
      errCnt += int'(obsErr);
      checkVal($sformatf("illegal_c%0d_busy", c), obsBusy, 0);
      checkVal($sformatf("illegal_c%0d_rden", c), obsRdEn, 0);
      tick();
    end
    checkVal("illegal_err_pulses", errCnt, 1);

    runOp(1'b1, 2'b00, 1065, 1'b0, 50);
    runOp(1'b1, 2'b00, 1065, 1'b0, -1);
    runOp(1'b1, 2'b00, 1065, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      rm = 2'($urandom_range(0, 2));
      runOp(1'b0, rm, (rm == 2'b10) ? 14 : 28, 1'b1, -1);
    end

    sel256 = 1'b0;
    tick();
    driveIn(1'b1, 2'b00);
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
    driveIn(1'b0, 2'b00);
    checkVal("rstprio_busy", obsBusy, 0);
    checkVal("rstprio_rden", obsRdEn, 0);
    tick();
    checkVal("rstprio_busy2", obsBusy, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
